// File: rtl/sequenciador_menor_distancia.sv
// sequenciador_menor_distancia: scans N_TEMPLATES distances over one shared unit and reports the unique strict minimum.
// Optional watchdog on each request enabled by defining DIST_TIMEOUT_EN.
module sequenciador_menor_distancia #(
    parameter int N_TEMPLATES = 10,
    parameter int DIST_W      = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              dist_req,
    output logic [3:0]        dist_idx,
    input  logic              dist_ack,
    input  logic [DIST_W-1:0] dist_val,
    output logic [3:0]        digito,
    output logic              done,
    output logic              tie,
    output logic              timeout
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [3:0] LAST = 4'(N_TEMPLATES - 1);
    state_t            state, state_n;
    logic [3:0]        idx, idx_n, min_idx, min_idx_n, digito_n;
    logic [DIST_W-1:0] min_val, min_val_n;
    logic              tie_r, tie_r_n, tie_n;
`ifdef DIST_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0]     wait_cnt, wait_cnt_n;
    logic              timeout_n;
`endif

    generate
        if (N_TEMPLATES < 2 || N_TEMPLATES > 15 || DIST_W < 1 || TIMEOUT < 1) begin : g_bad_params
            $error("sequenciador_menor_distancia: parameter out of range");
        end
    endgenerate

    // Outputs decode straight from the state register; no input feeds them combinationally.
    assign busy     = state != IDLE;
    assign dist_req = state == REQ;
    assign done     = state == DONE;
    assign dist_idx = idx;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        min_val_n = min_val;
        min_idx_n = min_idx;
        tie_r_n   = tie_r;
        digito_n  = digito;
        tie_n     = tie;
`ifdef DIST_TIMEOUT_EN
        wait_cnt_n = wait_cnt;
        timeout_n  = timeout;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = REQ;
                    idx_n   = 4'd0;
                    tie_r_n = 1'b0;
`ifdef DIST_TIMEOUT_EN
                    wait_cnt_n = '0;
`endif
                end
            end
            REQ: begin
                if (dist_ack) begin
                    // Index 0 seeds the running minimum unconditionally.
                    if (idx == 4'd0 || dist_val < min_val) begin
                        min_val_n = dist_val;
                        min_idx_n = idx;
                        tie_r_n   = 1'b0;
                    end else if (dist_val == min_val) begin
                        tie_r_n = 1'b1;
                    end
`ifdef DIST_TIMEOUT_EN
                    wait_cnt_n = '0;
`endif
                    if (idx == LAST) begin
                        state_n  = DONE;
                        digito_n = tie_r_n ? 4'd15 : min_idx_n;
                        tie_n    = tie_r_n;
`ifdef DIST_TIMEOUT_EN
                        timeout_n = 1'b0;
`endif
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
`ifdef DIST_TIMEOUT_EN
                // A late ack in the final allowed cycle wins over the watchdog.
                else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_n   = DONE;
                    digito_n  = 4'd15;
                    tie_n     = 1'b0;
                    timeout_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            min_val <= '0;
            min_idx <= 4'd0;
            tie_r   <= 1'b0;
            digito  <= 4'd15;
            tie     <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            min_val <= min_val_n;
            min_idx <= min_idx_n;
            tie_r   <= tie_r_n;
            digito  <= digito_n;
            tie     <= tie_n;
        end
    end

`ifdef DIST_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_n;
            timeout  <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif
endmodule
